// File: rtl/fa8.sv
// 8-bit ripple-carry adder built from eight 1-bit full adders.
// Combinational {Co,Y} result plus a registered copy with a signed-overflow flag.
`timescale 1ns/1ps

module fa8_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module fa8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Ci,
    output logic [7:0] Y,
    output logic       Co,
    output logic [7:0] Y_q,
    output logic       Co_q,
    output logic       V_q
);
    logic [8:0] w_c;
    logic [7:0] w_y;
    logic       w_ovf;

    logic [7:0] r_y;
    logic       r_co;
    logic       r_v;

    assign w_c[0] = Ci;

    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        fa8_bit u_bit (
            .i_a (A[gi]),
            .i_b (B[gi]),
            .i_c (w_c[gi]),
            .o_s (w_y[gi]),
            .o_c (w_c[gi+1])
        );
    end

    // Overflow looks only at operand and result sign bits; Ci is already folded into Y.
    assign w_ovf = (A[7] == B[7]) && (w_y[7] != A[7]);

    // No enable or handshake: the result is captured on every rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y  <= 8'h00;
            r_co <= 1'b0;
            r_v  <= 1'b0;
        end else begin
            r_y  <= w_y;
            r_co <= w_c[8];
            r_v  <= w_ovf;
        end
    end

    assign Y    = w_y;
    assign Co   = w_c[8];
    assign Y_q  = r_y;
    assign Co_q = r_co;
    assign V_q  = r_v;
endmodule

// File: tb/tb_fa8.sv
// Directed and random checks of fa8: combinational sum 25 ns after each input change,
// registered result one clock later via an expected-value queue, and async reset.
`timescale 1ns/1ps

module tb_fa8;
    logic       clk;
    logic       rst_n;
    logic [7:0] A;
    logic [7:0] B;
    logic       Ci;
    logic [7:0] Y;
    logic       Co;
    logic [7:0] Y_q;
    logic       Co_q;
    logic       V_q;

    int n_tests = 0;
    int n_fail  = 0;

    // Entries are {V, Co, Y} expected at the registered outputs.
    logic [9:0] exp_q[$];

    fa8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .Y     (Y),
        .Co    (Co),
        .Y_q   (Y_q),
        .Co_q  (Co_q),
        .V_q   (V_q)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic ci);
        logic [8:0] s;
        logic       v;
        s = {1'b0, a} + {1'b0, b} + {8'b0, ci};
        v = (a[7] == b[7]) && (s[7] != a[7]);
        return {v, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one operand set mid-cycle, check the combinational result after 25 ns,
    // then check the registered result just after the next rising edge.
    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci);
        logic [9:0] e;
        logic [9:0] got;
        @(negedge clk);
        A  = a;
        B  = b;
        Ci = ci;
        e  = model(a, b, ci);
        exp_q.push_back(e);
        #25;
        chk({tag, "_comb"}, {23'b0, Co, Y}, {23'b0, e[8:0]});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_qempty"}, 32'd0, 32'd1);
        end else begin
            got = exp_q.pop_front();
            chk({tag, "_reg"}, {22'b0, V_q, Co_q, Y_q}, {22'b0, got});
        end
    endtask

    initial begin
        logic [9:0] e;
        rst_n = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        Ci    = 1'b0;

        #10;
        chk("rst_comb", {23'b0, Co, Y}, 32'h000);
        chk("rst_reg",  {22'b0, V_q, Co_q, Y_q}, 32'h000);

        @(negedge clk);
        rst_n = 1'b1;

        step("ff_01",     8'hFF, 8'h01, 1'b0);
        step("7f_01",     8'h7F, 8'h01, 1'b0);
        step("ff_ff_c1",  8'hFF, 8'hFF, 1'b1);
        step("80_80",     8'h80, 8'h80, 1'b0);
        step("00_00_c1",  8'h00, 8'h00, 1'b1);
        step("80_ff",     8'h80, 8'hFF, 1'b0);
        step("7f_7f",     8'h7F, 8'h7F, 1'b0);

        // Mid-cycle reset while Y_q=FE and V_q=1: registers clear without a clock edge.
        #20;
        rst_n = 1'b0;
        #1;
        chk("midrst_reg", {22'b0, V_q, Co_q, Y_q}, 32'h000);
        A  = 8'h55;
        B  = 8'hC3;
        Ci = 1'b1;
        #25;
        e = model(8'h55, 8'hC3, 1'b1);
        chk("midrst_comb", {23'b0, Co, Y}, {23'b0, e[8:0]});
        @(posedge clk);
        #1;
        chk("midrst_hold", {22'b0, V_q, Co_q, Y_q}, 32'h000);

        // First rising edge after release captures the sum already on the inputs.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_capture", {22'b0, V_q, Co_q, Y_q}, {22'b0, e});

        for (int i = 0; i < 256; i++) begin
            step("rand", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 (i >= 128) ? 1'b1 : 1'b0);
        end

        chk("q_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
